// File: rtl/mult_pkg.sv
// ---- mult_pkg: shared types and helpers for the radix-4 Booth multiplier (rev 1.0) ----
`default_nettype none

package mult_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [2:0] digit_t;

  localparam digit_t ZERO = 3'd0;
  localparam digit_t POS1 = 3'd1;
  localparam digit_t POS2 = 3'd2;
  localparam digit_t NEG1 = 3'd3;
  localparam digit_t NEG2 = 3'd4;

  // Operands are extended by two bits, so WIDTH+2 multiplier bits give WIDTH/2+1 digits.
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_radix4_encoder.sv
// ---- booth_radix4_encoder: radix-4 Booth recode of one window into a partial product (rev 1.0) ----
`default_nettype none

module booth_radix4_encoder
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+2:0] pp
);

  digit_t           digit;
  logic [WIDTH+2:0] mult1;
  logic [WIDTH+2:0] mult2;

  assign mult1 = {mcand[WIDTH+1], mcand};
  assign mult2 = {mcand, 1'b0};

  always_comb begin
    digit = ZERO;
    case (window)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

  always_comb begin
    pp = '0;
    case (digit)
      POS1:    pp = mult1;
      POS2:    pp = mult2;
      NEG1:    pp = -mult1;
      NEG2:    pp = -mult2;
      default: pp = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mult_booth_seq.sv
// ---- mult_booth_seq: iterative radix-4 Booth multiplier, one digit per clock (rev 1.0) ----
`default_nettype none

module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int ITER  = booth_iters(WIDTH);
  localparam int CW    = $clog2(ITER + 1);
  localparam int AW    = 2 * WIDTH + 4;
  localparam int ALIGN = WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             last;
  logic [CW-1:0]    count;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH+2:0] mplier;
  logic [WIDTH+2:0] pp;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_sum;
  logic [AW-1:0]    acc_next;
  logic             ext_a;
  logic             ext_b;

  assign ext_a = is_signed & a[WIDTH-1];
  assign ext_b = is_signed & b[WIDTH-1];

  booth_radix4_encoder #(
    .WIDTH (WIDTH)
  ) u_encoder (
    .window (mplier[2:0]),
    .mcand  (mcand),
    .pp     (pp)
  );

  // Each digit enters at the top (weight 2^(WIDTH+2)) and the accumulator shifts right
  // by 2; after ITER steps the first digit has reached weight 1. Low bits shifted out are
  // always zero, and the running sum never exceeds the signed range of AW bits.
  assign acc_sum  = acc + AW'({pp, {ALIGN{1'b0}}});
  assign acc_next = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == LAST) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= last;
      busy <= (state_next == RUN);
      if (accept) begin
        mcand  <= {{2{ext_a}}, a};
        mplier <= {{2{ext_b}}, b, 1'b0};
        acc    <= '0;
        count  <= '0;
      end else if (state == RUN) begin
        acc    <= acc_next;
        mplier <= mplier >> 2;
        count  <= count + CW'(1);
        if (last) begin
          {hi, lo} <= acc_next[2*WIDTH-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_booth_seq.sv
// ---- tb_mult_booth_seq: scoreboard bench for 32-bit and 8-bit Booth multiplier instances (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module tb_mult_booth_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        start32 = 1'b0;
  logic        sg32    = 1'b0;
  logic [31:0] a32     = '0;
  logic [31:0] b32     = '0;
  logic [31:0] hi32;
  logic [31:0] lo32;
  logic        busy32;
  logic        done32;

  logic        start8 = 1'b0;
  logic        sg8    = 1'b0;
  logic [7:0]  a8     = '0;
  logic [7:0]  b8     = '0;
  logic [7:0]  hi8;
  logic [7:0]  lo8;
  logic        busy8;
  logic        done8;

  int          checks    = 0;
  int          passed    = 0;
  int          done_cnt32 = 0;
  int          done_cnt8  = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic [7:0]  corners [8] = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

  always #5 clock = ~clock;

  mult_booth_seq #(.WIDTH(32)) u_dut32 (
    .clock     (clock),
    .reset     (reset),
    .start     (start32),
    .is_signed (sg32),
    .a         (a32),
    .b         (b32),
    .hi        (hi32),
    .lo        (lo32),
    .busy      (busy32),
    .done      (done32)
  );

  mult_booth_seq #(.WIDTH(8)) u_dut8 (
    .clock     (clock),
    .reset     (reset),
    .start     (start8),
    .is_signed (sg8),
    .a         (a8),
    .b         (b8),
    .hi        (hi8),
    .lo        (lo8),
    .busy      (busy8),
    .done      (done8)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Sign/zero extension to the full product width makes a truncated multiply exact mod 2^(2W).
  function automatic logic [63:0] model32(input logic sg, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = sg ? {{32{x[31]}}, x} : {32'h0, x};
    ye = sg ? {{32{y[31]}}, y} : {32'h0, y};
    return xe * ye;
  endfunction

  function automatic logic [15:0] model8(input logic sg, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] xe, ye;
    xe = sg ? {{8{x[7]}}, x} : {8'h0, x};
    ye = sg ? {{8{y[7]}}, y} : {8'h0, y};
    return xe * ye;
  endfunction

  always @(negedge clock) begin
    if (done32) begin
      done_cnt32++;
      if (q32.size() == 0) check_value("spurious_done32", 64'(q32.size()), 64'd1);
      else check_value("result32", {hi32, lo32}, q32.pop_front());
    end
    if (done8) begin
      done_cnt8++;
      if (q8.size() == 0) check_value("spurious_done8", 64'(q8.size()), 64'd1);
      else check_value("result8", {48'h0, hi8, lo8}, {48'h0, q8.pop_front()});
    end
  end

  // lat counts edges from the start edge (inclusive) to the edge that raises done.
  task automatic run_op(input bit w8, input logic sg, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, output int lat, output int busy_n);
    logic dn;
    @(posedge clock); #1;
    if (w8) begin
      start8 = 1'b1; sg8 = sg; a8 = x[7:0]; b8 = y[7:0];
      q8.push_back(exp[15:0]);
    end else begin
      start32 = 1'b1; sg32 = sg; a32 = x; b32 = y;
      q32.push_back(exp);
    end
    @(posedge clock); #1;
    start8 = 1'b0; start32 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sg8 = ~sg8;
    a32 = $urandom; b32 = $urandom; sg32 = ~sg32;
    lat = 1; busy_n = 0;
    dn = w8 ? done8 : done32;
    while (!dn && lat < 64) begin
      if (w8 ? busy8 : busy32) busy_n++;
      @(posedge clock); #1;
      lat++;
      dn = w8 ? done8 : done32;
    end
    if (!dn) check_value("timeout", 64'(dn), 64'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   lat, bn, n, cnt_before;
    logic hold_ok;
    logic sg;
    logic [31:0] x, y;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_value("rst_hilo32", {hi32, lo32}, 64'd0);
    check_value("rst_flags32", {62'd0, busy32, done32}, 64'd0);
    check_value("rst_all8", {46'd0, hi8, lo8, busy8, done8}, 64'd0);

    run_op(0, 1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, lat, bn);
    check_value("lat32", 64'(lat), 64'd18);
    check_value("busy_cycles32", 64'(bn), 64'd17);
    check_value("busy_in_done32", 64'(busy32), 64'd0);
    @(posedge clock); #1;
    check_value("done_width32", 64'(done32), 64'd0);

    run_op(0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, lat, bn);
    run_op(0, 1'b0, 32'h80000000, 32'd2, 64'h00000001_00000000, lat, bn);
    run_op(0, 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, lat, bn);

    // Start ignored while busy, then back-to-back start in the done cycle.
    @(posedge clock); #1;
    start32 = 1'b1; sg32 = 1'b0; a32 = 32'd5; b32 = 32'd6; q32.push_back(64'd30);
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    start32 = 1'b1; sg32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    @(posedge clock); #1;
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    n = 0;
    while (!done32 && n < 64) begin
      @(posedge clock); #1;
      n++;
    end
    check_value("hs_first_done", 64'(done32), 64'd1);
    start32 = 1'b1; sg32 = 1'b0; a32 = 32'd2; b32 = 32'd3; q32.push_back(64'd6);
    @(posedge clock); #1;
    start32 = 1'b0;
    hold_ok = 1'b1; n = 0;
    while (!done32 && n < 64) begin
      if ({hi32, lo32} !== 64'd30) hold_ok = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    check_value("hs_hold", 64'(hold_ok), 64'd1);
    check_value("hs_b2b_done", 64'(done32), 64'd1);
    check_value("hs_b2b_lat", 64'(n + 1), 64'd18);

    // Reset in the middle of an operation.
    @(posedge clock); #1;
    cnt_before = done_cnt32;
    start32 = 1'b1; sg32 = 1'b0; a32 = 32'd100; b32 = 32'd100; q32.push_back(64'd10000);
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    q32.delete();
    check_value("abort_hilo", {hi32, lo32}, 64'd0);
    check_value("abort_flags", {62'd0, busy32, done32}, 64'd0);
    repeat (30) @(posedge clock);
    #1;
    check_value("abort_no_done", 64'(done_cnt32 - cnt_before), 64'd0);
    run_op(0, 1'b0, 32'd4, 32'd4, 64'd16, lat, bn);

    for (int i = 0; i < 40; i++) begin
      x = $urandom; y = $urandom; sg = 1'($urandom_range(0, 1));
      run_op(0, sg, x, y, model32(sg, x, y), lat, bn);
    end

    run_op(1, 1'b0, 32'd200, 32'd3, 64'h0258, lat, bn);
    check_value("lat8", 64'(lat), 64'd6);
    check_value("busy_cycles8", 64'(bn), 64'd5);
    run_op(1, 1'b1, 32'h80, 32'hFF, 64'h0080, lat, bn);
    run_op(1, 1'b1, 32'h80, 32'h80, 64'h4000, lat, bn);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          run_op(1, 1'(s), 32'(corners[i]), 32'(corners[j]),
                 64'(model8(1'(s), corners[i], corners[j])), lat, bn);
        end
      end
    end

    for (int i = 0; i < 800; i++) begin
      x = 32'($urandom_range(0, 255)); y = 32'($urandom_range(0, 255));
      sg = 1'($urandom_range(0, 1));
      run_op(1, sg, x, y, 64'(model8(sg, x[7:0], y[7:0])), lat, bn);
    end

    repeat (3) @(posedge clock);
    #1;
    check_value("drained32", 64'(q32.size()), 64'd0);
    check_value("drained8", 64'(q8.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
